// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter and its round-robin picker.
// rr_pick supports up to PICK_MAXN requesters.
package adder_arb_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } arb_state_t;

    localparam int unsigned STAT_CNTW = 16;
    localparam int unsigned PICK_MAXN = 16;
    localparam int unsigned PICK_IDXW = 4;
    localparam int unsigned PICK_JW   = PICK_IDXW + 1;

    // First set bit of valid searching ptr, ptr+1, ... modulo num.
    function automatic logic [PICK_IDXW-1:0] rr_pick(
        input logic [PICK_MAXN-1:0] valid,
        input logic [PICK_IDXW-1:0] ptr,
        input int unsigned          num
    );
        logic [PICK_JW-1:0] j;
        logic               found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < PICK_MAXN; k++) begin
            j = {1'b0, ptr} + PICK_JW'(k);
            if (j >= PICK_JW'(num)) begin
                j = j - PICK_JW'(num);
            end
            if (!found && k < num && valid[j[PICK_IDXW-1:0]]) begin
                found   = 1'b1;
                rr_pick = j[PICK_IDXW-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: valid vector + pointer -> index.
// Shared with multi-PE schedulers.
module rr_priority_pick
    import adder_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    assign idx       = IW'(rr_pick(PICK_MAXN'(valid), PICK_IDXW'(ptr), N));
    assign any_valid = |valid;

endmodule

// File: rtl/adder_arbiter.sv
// Packet-locked round-robin arbiter feeding one AXI-Stream adder PE.
// Define ADDER_ARB_STATS_EN to enable per-requester packet counters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TDATAW  = 32,
    parameter int unsigned TDESTW  = 4,
    parameter int unsigned TIDW    = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_REQ-1:0]          AXIS_S_TVALID,
    output logic [NUM_REQ-1:0]          AXIS_S_TREADY,
    input  logic [NUM_REQ*TDATAW-1:0]   AXIS_S_TDATA,
    input  logic [NUM_REQ-1:0]          AXIS_S_TLAST,
    input  logic [NUM_REQ*TDESTW-1:0]   AXIS_S_TDEST,
    output logic                        AXIS_M_TVALID,
    input  logic                        AXIS_M_TREADY,
    output logic [TDATAW-1:0]           AXIS_M_TDATA,
    output logic                        AXIS_M_TLAST,
    output logic [TIDW-1:0]             AXIS_M_TID,
    output logic [TDESTW-1:0]           AXIS_M_TDEST,
    output logic                        GRANT_ACTIVE,
    output logic [NUM_REQ*STAT_CNTW-1:0] STAT_PKT_CNT
);

    arb_state_t    state;
    arb_state_t    next_state;
    logic [TIDW-1:0] grant;
    logic [TIDW-1:0] rr_ptr;
    logic [TIDW-1:0] pick;
    logic            any_valid;
    logic            hs;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (TIDW)
    ) u_pick (
        .valid     (AXIS_S_TVALID),
        .ptr       (rr_ptr),
        .idx       (pick),
        .any_valid (any_valid)
    );

    assign hs = AXIS_M_TVALID & AXIS_M_TREADY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_valid) begin
                grant <= pick;
            end
            if (state == XFER && hs && AXIS_M_TLAST) begin
                rr_ptr <= (grant == TIDW'(NUM_REQ - 1)) ? '0 : grant + TIDW'(1);
            end
        end
    end

    // Ready is a function of state, grant and M_TREADY only (no S_TVALID path).
    always_comb begin
        next_state    = state;
        AXIS_S_TREADY = '0;
        AXIS_M_TVALID = 1'b0;
        AXIS_M_TDATA  = '0;
        AXIS_M_TLAST  = 1'b0;
        AXIS_M_TID    = '0;
        AXIS_M_TDEST  = '0;
        GRANT_ACTIVE  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    next_state = XFER;
                end
            end
            XFER: begin
                GRANT_ACTIVE         = 1'b1;
                AXIS_M_TVALID        = AXIS_S_TVALID[grant];
                AXIS_M_TDATA         = AXIS_S_TDATA[grant*TDATAW +: TDATAW];
                AXIS_M_TLAST         = AXIS_S_TLAST[grant];
                AXIS_M_TDEST         = AXIS_S_TDEST[grant*TDESTW +: TDESTW];
                AXIS_M_TID           = grant;
                AXIS_S_TREADY[grant] = AXIS_M_TREADY;
                if (AXIS_S_TVALID[grant] && AXIS_M_TREADY && AXIS_S_TLAST[grant]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ADDER_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_CNTW-1:0] pkt_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pkt_cnt <= '0;
        end else if (hs && AXIS_M_TLAST && pkt_cnt[grant] != '1) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + STAT_CNTW'(1);
        end
    end

    assign STAT_PKT_CNT = pkt_cnt;
`else
    assign STAT_PKT_CNT = '0;
`endif

`ifndef SYNTHESIS
    if (NUM_REQ > 2**TIDW || NUM_REQ > PICK_MAXN || NUM_REQ < 2) begin : g_bad_cfg
        $error("adder_arbiter: NUM_REQ out of range for TIDW");
    end

    a_grant_range: assert property (
        @(posedge CLK) disable iff (!RST_N) int'(grant) < int'(NUM_REQ));

    a_ready_onehot: assert property (
        @(posedge CLK) disable iff (!RST_N) $onehot0(AXIS_S_TREADY));
`endif

endmodule
